// File: rtl/instr_encoder_loader_pkg.sv
// Shared encoding constants for the instruction loader and the Control decoder.
// Opcodes, funct codes, operation selector and loader FSM state encoding.
package instr_encoder_loader_pkg;

  localparam logic [5:0] OPC_LW    = 6'b010010;
  localparam logic [5:0] OPC_SW    = 6'b010011;
  localparam logic [5:0] OPC_RTYPE = 6'b010001;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_MUL = 6'b110010;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_SW  = 3'd1,
    OP_ADD = 3'd2,
    OP_SUB = 3'd3,
    OP_MUL = 3'd4
  } op_sel_e;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCEPT = 2'd1;
  localparam logic [1:0] ST_WRITE  = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

  function automatic logic [31:0] enc_rtype(input logic [4:0] rs, input logic [4:0] rt,
                                            input logic [4:0] rd, input logic [5:0] funct);
    return {OPC_RTYPE, rs, rt, rd, 5'b00000, funct};
  endfunction

endpackage

// File: rtl/instr_encoder_loader_if.sv
// Symbolic-operation handshake between an instruction source and the loader.
// The source holds all fields stable while Op_Valid is high until accepted.
interface instr_encoder_loader_if;
  logic       Op_Valid;
  logic       Op_Ready;
  logic [2:0] Op_Sel;
  logic [4:0] Rs;
  logic [4:0] Rt;
  logic [4:0] Rd;
  logic [15:0] Offset;

  modport master (output Op_Valid, Op_Sel, Rs, Rt, Rd, Offset, input Op_Ready);
  modport slave  (input Op_Valid, Op_Sel, Rs, Rt, Rd, Offset, output Op_Ready);
endinterface

// File: rtl/instr_encoder_loader_pack.sv
// Combinational packer: symbolic operation fields to a 32-bit instruction word.
// Zero latency; illegal selectors yield word 0 with the illegal flag raised.
module instr_pack
  import instr_encoder_loader_pkg::*;
(
  input  logic [2:0]  op_sel_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [15:0] offset_i,
  output logic [31:0] word_o,
  output logic        illegal_o
);

  always_comb begin
    word_o    = '0;
    illegal_o = 1'b0;
    case (op_sel_i)
      OP_LW:   word_o = {OPC_LW, rs_i, rt_i, offset_i};
      OP_SW:   word_o = {OPC_SW, rs_i, rt_i, offset_i};
      OP_ADD:  word_o = enc_rtype(rs_i, rt_i, rd_i, FN_ADD);
      OP_SUB:  word_o = enc_rtype(rs_i, rt_i, rd_i, FN_SUB);
      OP_MUL:  word_o = enc_rtype(rs_i, rt_i, rd_i, FN_MUL);
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Loads a program of encoded instructions into memory from a base address.
// One write per accepted op, strobe the cycle after handshake; no wrap at memory end.
module instr_encoder_loader
  import instr_encoder_loader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 8
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              Start,
  input  logic [ADDR_W-1:0] Base_Addr,
  input  logic [LEN_W-1:0]  Prog_Len,
  instr_encoder_loader_if.slave op,
  output logic              Mem_We,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [31:0]       Mem_Wdata,
  output logic [LEN_W-1:0]  Count,
  output logic              Busy,
  output logic              Done,
  output logic              Error
);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [LEN_W-1:0]  count_q, count_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;

  logic [31:0] pack_word;
  logic        pack_illegal;

  instr_pack u_pack (
    .op_sel_i  (op.Op_Sel),
    .rs_i      (op.Rs),
    .rt_i      (op.Rt),
    .rd_i      (op.Rd),
    .offset_i  (op.Offset),
    .word_o    (pack_word),
    .illegal_o (pack_illegal)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    mem_addr_d = mem_addr_q;
    rem_d      = rem_q;
    count_d    = count_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          count_d = '0;
          err_d   = 1'b0;
          if (Prog_Len == '0) begin
            state_d = ST_FINISH;
          end else begin
            addr_d  = Base_Addr;
            rem_d   = Prog_Len;
            state_d = ST_ACCEPT;
          end
        end
      end
      ST_ACCEPT: begin
        if (op.Op_Valid) begin
          if (pack_illegal) begin
            err_d   = 1'b1;
            state_d = ST_FINISH;
          end else begin
            wdata_d    = pack_word;
            mem_addr_d = addr_q;
            state_d    = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        count_d = count_q + 1'b1;
        addr_d  = addr_q + 1'b1;
        rem_d   = rem_q - 1'b1;
        if (rem_q == LEN_W'(1)) begin
          state_d = ST_FINISH;
        end else if (&addr_q) begin
          // Memory end reached with instructions still pending: stop rather than wrap.
          err_d   = 1'b1;
          state_d = ST_FINISH;
        end else begin
          state_d = ST_ACCEPT;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      mem_addr_q <= '0;
      rem_q      <= '0;
      count_q    <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      mem_addr_q <= mem_addr_d;
      rem_q      <= rem_d;
      count_q    <= count_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
    end
  end

  assign op.Op_Ready = (state_q == ST_ACCEPT);
  assign Busy        = (state_q == ST_ACCEPT) || (state_q == ST_WRITE);
  assign Mem_We      = (state_q == ST_WRITE);
  assign Done        = (state_q == ST_FINISH);
  assign Mem_Addr    = mem_addr_q;
  assign Mem_Wdata   = wdata_q;
  assign Count       = count_q;
  assign Error       = err_q;

endmodule
